rgb_sinp: RTL and testbench

Serial-input front end of the RGB-to-RGBW path. Synchronizes the raw WS2812-style single-wire input, measures pulse timing against `clk`, and emits one strobe per decoded data bit or per detected stream reset (≥50 µs low). Its outputs drive `in_strobe`/`in_sbit_value`/`in_stream_reset` of `rgb_sbit2wrd` directly. Timing assumes `clk` is treated as 96 MHz.

---
 rtl/rgb_pkg.sv | 18 +
 rtl/rgb_sync_edge.sv | 32 +++
 rtl/rgb_sinp.sv | 155 +++++++++++++++
 tb/tb_rgb_sinp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared constants and state encoding for the RGB serial-input front end.
// Pulse timing figures assume a 96 MHz clock.
package rgb_pkg;

    localparam int SAMPLE_TIME_CLKS  = 57;
    localparam int STREAM_RESET_CLKS = 4800;
    localparam int MIN_HIGH_CLKS     = 8;
    localparam int COUNTER_MAX       = STREAM_RESET_CLKS + 200;

    typedef enum logic [2:0] {
        ST_WAIT_RST = 3'd0,
        ST_IDLE     = 3'd1,
        ST_BIT      = 3'd2,
        ST_HIGH     = 3'd3,
        ST_LOW      = 3'd4
    } state_t;

endpackage

// File: rtl/rgb_sync_edge.sv
// Two-flop synchronizer for the raw serial line plus one delay flop
// used to derive single-cycle rise and fall indications.
module rgb_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_serial,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_s;
    logic r_s_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_s    <= 1'b0;
            r_s_d  <= 1'b0;
        end else begin
            r_meta <= i_serial;
            r_s    <= r_meta;
            r_s_d  <= r_s;
        end
    end

    assign o_s    = r_s;
    assign o_rise = r_s & ~r_s_d;
    assign o_fall = ~r_s & r_s_d;

endmodule

// File: rtl/rgb_sinp.sv
// WS2812-style single-wire decoder: measures pulse widths and emits one
// registered strobe per data bit or per detected stream reset.
module rgb_sinp #(
    parameter int SAMPLE_TIME_CLKS  = rgb_pkg::SAMPLE_TIME_CLKS,
    parameter int STREAM_RESET_CLKS = rgb_pkg::STREAM_RESET_CLKS,
    parameter int MIN_HIGH_CLKS     = rgb_pkg::MIN_HIGH_CLKS,
    parameter int COUNTER_MAX       = STREAM_RESET_CLKS + 200
) (
    input  logic clk,
    input  logic rst,
    input  logic in_serial,
    output logic out_strobe,
    output logic out_sbit_value,
    output logic out_stream_reset,
    output logic out_err
);

    import rgb_pkg::*;

    localparam int CW = $clog2(COUNTER_MAX + 1);
    localparam logic [CW-1:0] L_SAMPLE = CW'(SAMPLE_TIME_CLKS);
    localparam logic [CW-1:0] L_SRST   = CW'(STREAM_RESET_CLKS);
    localparam logic [CW-1:0] L_MINH   = CW'(MIN_HIGH_CLKS);
    localparam logic [CW-1:0] L_MAX    = CW'(COUNTER_MAX);
    localparam logic [CW-1:0] L_ONE    = CW'(1);

    logic w_s;
    logic w_rise;
    logic w_fall;

    rgb_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_serial (in_serial),
        .o_s      (w_s),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_from_low;
    logic          w_from_low_nxt;
    logic          w_strobe;
    logic          w_val;
    logic          w_srst;
    logic          w_err;
    logic          r_strobe;
    logic          r_val;
    logic          r_srst;
    logic          r_err;

    assign w_cnt_inc = (r_cnt == L_MAX) ? r_cnt : r_cnt + L_ONE;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_cnt_inc;
        w_from_low_nxt = r_from_low;
        w_strobe       = 1'b0;
        w_val          = 1'b0;
        w_srst         = 1'b0;
        w_err          = 1'b0;
        unique case (r_state)
            ST_WAIT_RST: begin
                if (r_cnt == L_SRST) begin
                    w_strobe    = 1'b1;
                    w_srst      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_s) begin
                    w_cnt_nxt = '0;
                end
            end
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt    = ST_BIT;
                    w_cnt_nxt      = L_ONE;
                    w_from_low_nxt = 1'b0;
                end
            end
            ST_BIT: begin
                // Sample point wins over a coincident fall; s is already 0 then.
                if (r_cnt == L_SAMPLE) begin
                    w_strobe = 1'b1;
                    w_val    = w_s;
                    if (w_s) begin
                        w_state_nxt = ST_HIGH;
                    end else begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_fall && (r_cnt < L_MINH)) begin
                    w_state_nxt = r_from_low ? ST_LOW : ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == L_MAX) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_WAIT_RST;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_state_nxt    = ST_BIT;
                    w_cnt_nxt      = L_ONE;
                    w_from_low_nxt = 1'b1;
                end else if (r_cnt == L_SRST) begin
                    w_strobe    = 1'b1;
                    w_srst      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_WAIT_RST;
            r_cnt      <= '0;
            r_from_low <= 1'b0;
            r_strobe   <= 1'b0;
            r_val      <= 1'b0;
            r_srst     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_from_low <= w_from_low_nxt;
            r_strobe   <= w_strobe;
            r_val      <= w_val;
            r_srst     <= w_srst;
            r_err      <= w_err;
        end
    end

    assign out_strobe       = r_strobe;
    assign out_sbit_value   = r_val;
    assign out_stream_reset = r_srst;
    assign out_err          = r_err;

endmodule

// File: tb/tb_rgb_sinp.sv
// Directed bench for rgb_sinp: timed strobe events are logged by a monitor
// and compared against hand-derived clock positions.
module tb_rgb_sinp;

    localparam int T_BIT  = 59;    // rise capture -> bit strobe
    localparam int T_SRST = 4802;  // low capture -> stream-reset strobe
    localparam int T_ERR  = 5002;  // rise capture -> stuck-high error

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_serial = 1'b0;
    logic out_strobe;
    logic out_sbit_value;
    logic out_stream_reset;
    logic out_err;

    always #5 clk = ~clk;

    rgb_sinp dut (
        .clk              (clk),
        .rst              (rst),
        .in_serial        (in_serial),
        .out_strobe       (out_strobe),
        .out_sbit_value   (out_sbit_value),
        .out_stream_reset (out_stream_reset),
        .out_err          (out_err)
    );

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int bad_val = 0;
    int ev_cyc[$];
    bit ev_val[$];
    bit ev_srst[$];
    int err_cyc[$];

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (out_strobe) begin
            ev_cyc.push_back(cyc);
            ev_val.push_back(out_sbit_value);
            ev_srst.push_back(out_stream_reset);
        end
        if (out_err)
            err_cyc.push_back(cyc);
        if ((out_sbit_value && (!out_strobe || out_stream_reset)) ||
            (out_stream_reset && !out_strobe))
            bad_val++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clr();
        ev_cyc.delete();
        ev_val.delete();
        ev_srst.delete();
        err_cyc.delete();
    endtask

    task automatic send_bit(input bit b, output int t);
        in_serial = 1'b1;
        t = cyc + 1;
        step(b ? 77 : 38);
        in_serial = 1'b0;
        step(b ? 43 : 82);
    endtask

    initial begin
        int rel, t, t0, tg, tl, x;
        int ts[24];
        logic [23:0] word;
        logic [23:0] got_w;
        int nbad;

        step(5);
        chk("rst_strobe", int'(out_strobe), 0);
        chk("rst_val", int'(out_sbit_value), 0);
        chk("rst_srst", int'(out_stream_reset), 0);
        chk("rst_err", int'(out_err), 0);

        // Reset already holds the synchronizer low, so counting starts
        // on the first edge after release.
        clr();
        rst = 1'b1;
        rel = cyc;
        step(4801 + 10000);
        chk("init_srst_n", ev_cyc.size(), 1);
        if (ev_cyc.size() >= 1) begin
            chk("init_srst_cyc", ev_cyc[0], rel + 4801);
            chk("init_srst_flag", int'(ev_srst[0]), 1);
        end
        chk("init_err_n", err_cyc.size(), 0);

        clr();
        send_bit(1'b0, t);
        step(10);
        chk("bit0_n", ev_cyc.size(), 1);
        if (ev_cyc.size() >= 1) begin
            chk("bit0_cyc", ev_cyc[0], t + T_BIT);
            chk("bit0_val", int'(ev_val[0]), 0);
            chk("bit0_srst", int'(ev_srst[0]), 0);
        end

        clr();
        word = 24'hA5C3F0;
        for (int i = 23; i >= 0; i--)
            send_bit(word[i], ts[23 - i]);
        step(4900);
        chk("train_n", ev_cyc.size(), 25);
        if (ev_cyc.size() == 25) begin
            got_w = '0;
            nbad = 0;
            for (int i = 0; i < 24; i++) begin
                got_w = {got_w[22:0], ev_val[i]};
                if (ev_cyc[i] != ts[i] + T_BIT || ev_srst[i])
                    nbad++;
            end
            chk("train_word", int'(got_w), int'(word));
            chk("train_timing", nbad, 0);
            chk("train_srst_flag", int'(ev_srst[24]), 1);
            chk("train_srst_cyc", ev_cyc[24], ts[23] + 4860);
        end

        clr();
        send_bit(1'b0, t0);
        in_serial = 1'b1;
        tg = cyc + 1;
        step(4);
        in_serial = 1'b0;
        step(4900);
        chk("glitch_n", ev_cyc.size(), 2);
        if (ev_cyc.size() == 2) begin
            chk("glitch_bit_cyc", ev_cyc[0], t0 + T_BIT);
            chk("glitch_srst_cyc", ev_cyc[1], tg + 4807);
            chk("glitch_srst_flag", int'(ev_srst[1]), 1);
        end

        clr();
        in_serial = 1'b1;
        t = cyc + 1;
        step(5200);
        in_serial = 1'b0;
        step(43);
        send_bit(1'b1, x);
        send_bit(1'b1, x);
        tl = x + 77;
        step(4900);
        chk("stuck_n", ev_cyc.size(), 2);
        if (ev_cyc.size() == 2) begin
            chk("stuck_bit_cyc", ev_cyc[0], t + T_BIT);
            chk("stuck_bit_val", int'(ev_val[0]), 1);
            chk("stuck_srst_cyc", ev_cyc[1], tl + T_SRST);
            chk("stuck_srst_flag", int'(ev_srst[1]), 1);
        end
        chk("stuck_err_n", err_cyc.size(), 1);
        if (err_cyc.size() == 1)
            chk("stuck_err_cyc", err_cyc[0], t + T_ERR);

        clr();
        in_serial = 1'b1;
        step(30);
        rst = 1'b0;
        #1;
        chk("mid_rst_strobe", int'(out_strobe), 0);
        chk("mid_rst_err", int'(out_err), 0);
        step(5);
        rst = 1'b1;
        step(40);
        in_serial = 1'b0;
        tl = cyc + 1;
        step(4900);
        chk("mid_rst_n", ev_cyc.size(), 1);
        if (ev_cyc.size() == 1) begin
            chk("mid_rst_srst_cyc", ev_cyc[0], tl + T_SRST);
            chk("mid_rst_srst_flag", int'(ev_srst[0]), 1);
        end
        chk("mid_rst_err_n", err_cyc.size(), 0);

        chk("value_forced_zero", bad_val, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
